// File: rtl/case_5_sdiv_14s_12s_14_seq_1.sv
// Sequential signed divider: radix-2 restoring, one quotient bit per enabled cycle, C truncation semantics.
// Latency din0_WIDTH+1 enabled cycles from accept to done; ce=0 freezes all state; start ignored while busy.
module case_5_sdiv_14s_12s_14_seq_1 #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 14
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem
);

    localparam int N0 = din0_WIDTH;
    localparam int N1 = din1_WIDTH;
    localparam logic [3:0] LAST_ITER = 4'(N0 - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t          state_q, state_d;
    logic [N0-1:0]   a_q, a_d;        // dividend magnitude shifting out, quotient shifting in
    logic [N1-1:0]   b_q, b_d;
    logic [N1:0]     pr_q, pr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            s0_q, s0_d;
    logic            neg_q, neg_d;
    logic            z_q, z_d;
    logic [N1-1:0]   d0lo_q, d0lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N0-1:0]   quot_q, quot_d;
    logic [N1-1:0]   rem_q, rem_d;

    logic [N1:0]     shifted;
    logic [N1+1:0]   trial;

    // pr_q stays below |din1| <= 2^(N1-1), so dropping its top bit on the shift is lossless
    assign shifted = {pr_q[N1-1:0], a_q[N0-1]};
    assign trial   = {1'b0, shifted} - {2'b00, b_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        neg_d   = neg_q;
        z_d     = z_q;
        d0lo_d  = d0lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = din0[N0-1] ? -din0 : din0;
                    b_d     = din1[N1-1] ? -din1 : din1;
                    s0_d    = din0[N0-1];
                    neg_d   = din0[N0-1] ^ din1[N1-1];
                    z_d     = (din1 == '0);
                    d0lo_d  = din0[N1-1:0];
                    pr_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!trial[N1+1]) begin
                    pr_d = trial[N1:0];
                    a_d  = {a_q[N0-2:0], 1'b1};
                end else begin
                    pr_d = shifted;
                    a_d  = {a_q[N0-2:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                // Divide by zero keeps the fixed latency; its datapath result is discarded
                if (z_q) begin
                    quot_d = '1;
                    rem_d  = d0lo_q;
                end else begin
                    quot_d = neg_q ? -a_q : a_q;
                    rem_d  = s0_q ? -pr_q[N1-1:0] : pr_q[N1-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            s0_q    <= 1'b0;
            neg_q   <= 1'b0;
            z_q     <= 1'b0;
            d0lo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            neg_q   <= neg_d;
            z_q     <= z_d;
            d0lo_q  <= d0lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_case_5_sdiv_14s_12s_14_seq_1.sv
// Scoreboard bench for the sequential signed divider: directed vectors, latency and handshake checks.
module tb_case_5_sdiv_14s_12s_14_seq_1;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ce     = 1'b1;
    logic        start  = 1'b0;
    logic [13:0] din0   = '0;
    logic [11:0] din1   = '0;
    logic        busy;
    logic        done;
    logic [13:0] quot;
    logic [11:0] rem;

    case_5_sdiv_14s_12s_14_seq_1 #(
        .ID(1), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(14)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .busy(busy), .done(done),
        .quot(quot), .rem(rem)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [13:0] q;
        logic [11:0] r;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic done_prev = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each new done pulse against the oldest expected result
    always @(negedge ap_clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=1 exp=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quot", 32'(quot), 32'(e.q));
                check("rem", 32'(rem), 32'(e.r));
                check("done_cycle", 32'(cyc), 32'(e.c));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
        done_prev = done;
    end

    // Present operands, wait for the accept edge, queue the expected result
    task automatic issue(input logic [13:0] a, input logic [11:0] b,
                         input logic [13:0] q, input logic [11:0] r, input int extra);
        exp_t e;
        @(negedge ap_clk);
        start = 1'b1;
        din0  = a;
        din1  = b;
        @(posedge ap_clk);
        #1;
        e.q = q;
        e.r = r;
        e.c = cyc + 15 + extra;
        sb.push_back(e);
        check("busy_after_accept", 32'(busy), 32'd1);
        @(negedge ap_clk);
        start = 1'b0;
        din0  = 14'($urandom);
        din1  = 12'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() > 0; i++) begin
            @(negedge ap_clk);
            #1;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d exp=0 pending", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", 32'(quot), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // Sign quadrants
        issue(14'd100,  12'd7,   14'd14,    12'd2,   0); drain();
        issue(-14'd100, 12'd7,   -14'd14,   -12'd2,  0); drain();
        issue(14'd100,  -12'd7,  -14'd14,   12'd2,   0); drain();
        issue(-14'd100, -12'd7,  14'd14,    -12'd2,  0); drain();

        // Boundaries
        issue(14'h2000, 12'hFFF, 14'h2000,  12'd0,   0); drain();
        issue(14'h1FFF, 12'h800, 14'h3FFD,  12'h7FF, 0); drain();
        issue(14'd5,    12'd9,   14'd0,     12'd5,   0); drain();

        // Divide by zero
        issue(14'd37,   12'd0,   14'h3FFF,  12'd37,  0); drain();
        issue(14'h3FFF, 12'd0,   14'h3FFF,  12'hFFF, 0); drain();

        // start pulses during a busy period must be ignored
        issue(14'd100, 12'd7, 14'd14, 12'd2, 0);
        repeat (2) @(negedge ap_clk);
        start = 1'b1; din0 = 14'd1234; din1 = 12'd3;
        @(negedge ap_clk);
        start = 1'b0;
        repeat (6) @(negedge ap_clk);
        start = 1'b1; din0 = 14'd999; din1 = 12'd5;
        @(negedge ap_clk);
        start = 1'b0;
        drain();

        // start held high through done: back-to-back with 16-cycle spacing
        begin
            exp_t e;
            int   c0;
            @(negedge ap_clk);
            start = 1'b1; din0 = 14'd100; din1 = 12'd7;
            @(posedge ap_clk);
            #1;
            c0 = cyc;
            e.q = 14'd14; e.r = 12'd2; e.c = c0 + 15;
            sb.push_back(e);
            e.q = 14'd14; e.r = -12'd2; e.c = c0 + 31;
            sb.push_back(e);
            @(negedge ap_clk);
            din0 = -14'd100; din1 = -12'd7;
            repeat (16) @(posedge ap_clk);
            @(negedge ap_clk);
            start = 1'b0; din0 = 14'd77; din1 = 12'd11;
            drain();
        end

        // ce dropped for 4 cycles mid-CALC extends latency to 19
        issue(14'd8000, 12'd33, 14'd242, 12'd14, 4);
        repeat (4) @(negedge ap_clk);
        ce = 1'b0;
        repeat (4) @(negedge ap_clk);
        ce = 1'b1;
        drain();

        // ce low in the done cycle keeps done asserted
        issue(14'd5, 12'd9, 14'd0, 12'd5, 0);
        for (int i = 0; i < 30 && !done; i++) @(negedge ap_clk);
        ce = 1'b0;
        repeat (3) begin
            @(negedge ap_clk);
            check("ce_hold_done", 32'(done), 32'd1);
        end
        ce = 1'b1;
        @(negedge ap_clk);
        check("done_clears", 32'(done), 32'd0);
        drain();

        // Asynchronous reset mid-CALC aborts the operation
        issue(14'd100, 12'd7, 14'd14, 12'd2, 0);
        repeat (7) @(negedge ap_clk);
        #3;
        ap_rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_quot", 32'(quot), 32'd0);
        check("arst_rem", 32'(rem), 32'd0);
        sb.delete();
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (25) @(negedge ap_clk);
        issue(14'h1FFF, 12'h800, 14'h3FFD, 12'h7FF, 0); drain();

        repeat (3) @(negedge ap_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
